// File: rtl/cam_capture_if.sv
// cam_capture_if: camera pin bundle into the capture engine and the
// assembled pixel bundle out of it.
interface cam_capture_if #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);

    logic          pclk_i;
    logic          href_i;
    logic          vsync_i;
    logic [7:0]    cam_data_i;
    logic [7:0]    pix_r_o;
    logic [7:0]    pix_g_o;
    logic [7:0]    pix_b_o;
    logic          pix_valid_o;
    logic          pix_sof_o;
    logic          pix_eol_o;
    logic [XW-1:0] x_o;
    logic [YW-1:0] y_o;

    modport master (
        output pclk_i, href_i, vsync_i, cam_data_i,
        input  pix_r_o, pix_g_o, pix_b_o,
        input  pix_valid_o, pix_sof_o, pix_eol_o, x_o, y_o
    );

    modport slave (
        input  pclk_i, href_i, vsync_i, cam_data_i,
        output pix_r_o, pix_g_o, pix_b_o,
        output pix_valid_o, pix_sof_o, pix_eol_o, x_o, y_o
    );
endinterface

// File: rtl/cam_capture.sv
// cam_capture: oversampled camera bus capture, byte pairing into
// RGB565 / RGB444 / YUV luma pixels with X/Y tracking and 1:DECIM.
module cam_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int DECIM       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic         sys_clk_i,
    input  logic         sys_rst_ni,
    input  logic         cap_en_i,
    input  logic [1:0]   mode_i,
    input  logic         err_clr_i,
    output logic         frame_done_o,
    output logic         busy_o,
    output logic         err_o,
    cam_capture_if.slave bus
);
    localparam int XW  = $clog2(H_ACTIVE + 1);
    localparam int YW  = $clog2(V_ACTIVE + 1);
    localparam int XOW = $clog2(H_ACTIVE);
    localparam int YOW = $clog2(V_ACTIVE);
    localparam logic [XW-1:0] X_END = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_END = YW'(V_ACTIVE);
    localparam logic [XW-1:0] X_EOL = XW'(H_ACTIVE - DECIM);
    localparam logic [XW-1:0] X_MSK = XW'(DECIM - 1);
    localparam logic [YW-1:0] Y_MSK = YW'(DECIM - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, DONE} state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0]      pclk_s, href_s, vs_s;
    logic [SYNC_STAGES-1:0][7:0] data_s;
    logic       pclk_q, pclk_d, href_q, href_d, vs_q, vs_d;
    logic [7:0] data_q;

    logic [XW-1:0] x_r, x_inc;
    logic [YW-1:0] y_r, y_inc, y_after;
    logic          phase, ph_cur, sof_pend;
    logic [7:0]    b0;
    logic [1:0]    mode_q;
    logic [7:0]    r8, g8, b8;

    logic tick, href_rise, href_fall, vs_rise, vs_fall;
    logic active, enter, line_end, frame_end, byte_ev;
    logic pix_take, emit, line_err, frame_err;

    // Edge detection runs one register behind the synchroniser so that
    // pclk, href and data are all compared at the same stage.
    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            pclk_s <= '0;
            href_s <= '0;
            vs_s   <= '0;
            data_s <= '0;
            pclk_q <= 1'b0;
            pclk_d <= 1'b0;
            href_q <= 1'b0;
            href_d <= 1'b0;
            vs_q   <= 1'b0;
            vs_d   <= 1'b0;
            data_q <= '0;
        end else begin
            pclk_s <= {pclk_s[SYNC_STAGES-2:0], bus.pclk_i};
            href_s <= {href_s[SYNC_STAGES-2:0], bus.href_i};
            vs_s   <= {vs_s[SYNC_STAGES-2:0], bus.vsync_i};
            data_s <= {data_s[SYNC_STAGES-2:0], bus.cam_data_i};
            pclk_q <= pclk_s[SYNC_STAGES-1];
            pclk_d <= pclk_q;
            href_q <= href_s[SYNC_STAGES-1];
            href_d <= href_q;
            vs_q   <= vs_s[SYNC_STAGES-1];
            vs_d   <= vs_q;
            data_q <= data_s[SYNC_STAGES-1];
        end
    end

    assign tick      = pclk_q & ~pclk_d;
    assign href_rise = href_q & ~href_d;
    assign href_fall = ~href_q & href_d;
    assign vs_rise   = vs_q & ~vs_d;
    assign vs_fall   = ~vs_q & vs_d;

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) state <= IDLE;
        else             state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (cap_en_i) state_n = WAIT_VS;
            WAIT_VS: begin
                if (!cap_en_i)    state_n = IDLE;
                else if (vs_fall) state_n = ACTIVE;
            end
            ACTIVE:  if (vs_rise) state_n = DONE;
            DONE:    state_n = cap_en_i ? WAIT_VS : IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy_o = (state == WAIT_VS) || (state == ACTIVE);
    assign active = (state == ACTIVE);
    assign enter  = (state == WAIT_VS) && (state_n == ACTIVE);

    // A frame ending with href still high closes that line first.
    assign line_end  = active & (href_fall | (vs_rise & href_q));
    assign frame_end = active & vs_rise;
    assign byte_ev   = active & ~vs_rise & tick & href_q;
    assign ph_cur    = href_rise ? 1'b0 : phase;
    assign pix_take  = byte_ev & ph_cur;

    assign x_inc   = (x_r == X_END) ? x_r : x_r + 1'b1;
    assign y_inc   = (y_r == Y_END) ? y_r : y_r + 1'b1;
    assign y_after = line_end ? y_inc : y_r;

    assign line_err  = line_end & ((x_r != X_END) | phase);
    assign frame_err = frame_end & (y_after != Y_END);

    assign emit = pix_take & (x_r < X_END) & (y_r < Y_END)
                & ((x_r & X_MSK) == '0) & ((y_r & Y_MSK) == '0);

    always_comb begin
        r8 = {b0[7:3], b0[7:5]};
        g8 = {b0[2:0], data_q[7:5], b0[2:1]};
        b8 = {data_q[4:0], data_q[4:2]};
        unique case (1'b1)
            mode_q == 2'b01: begin
                r8 = {b0[3:0], b0[3:0]};
                g8 = {data_q[7:4], data_q[7:4]};
                b8 = {data_q[3:0], data_q[3:0]};
            end
            mode_q == 2'b10: begin
                r8 = b0;
                g8 = b0;
                b8 = b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            x_r             <= '0;
            y_r             <= '0;
            phase           <= 1'b0;
            b0              <= '0;
            mode_q          <= '0;
            sof_pend        <= 1'b0;
            err_o           <= 1'b0;
            frame_done_o    <= 1'b0;
            bus.pix_valid_o <= 1'b0;
            bus.pix_sof_o   <= 1'b0;
            bus.pix_eol_o   <= 1'b0;
            bus.pix_r_o     <= '0;
            bus.pix_g_o     <= '0;
            bus.pix_b_o     <= '0;
            bus.x_o         <= '0;
            bus.y_o         <= '0;
        end else begin
            bus.pix_valid_o <= emit;
            frame_done_o    <= frame_end;
            if (line_err || frame_err) err_o <= 1'b1;
            else if (err_clr_i)        err_o <= 1'b0;

            if (enter) begin
                x_r      <= '0;
                y_r      <= '0;
                phase    <= 1'b0;
                sof_pend <= 1'b1;
                mode_q   <= (mode_i == 2'b11) ? 2'b00 : mode_i;
            end else if (line_end) begin
                x_r <= '0;
                y_r <= y_inc;
            end else if (byte_ev) begin
                if (ph_cur) begin
                    phase <= 1'b0;
                    x_r   <= x_inc;
                end else begin
                    phase <= 1'b1;
                    b0    <= data_q;
                end
            end else if (href_rise) begin
                phase <= 1'b0;
            end

            if (emit) begin
                sof_pend      <= 1'b0;
                bus.pix_sof_o <= sof_pend;
                bus.pix_eol_o <= (x_r == X_EOL);
                bus.pix_r_o   <= r8;
                bus.pix_g_o   <= g8;
                bus.pix_b_o   <= b8;
                bus.x_o       <= x_r[XOW-1:0];
                bus.y_o       <= y_r[YOW-1:0];
            end
        end
    end
endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: directed frames into a 4x2 DECIM=1 engine and a
// 4x4 DECIM=2 engine sharing the same camera pins.
module tb_cam_capture;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, cap_en, err_clr;
    logic [1:0] mode;
    logic       pclk, href, vsync;
    logic [7:0] cdata;
    logic       fd_a, busy_a, err_a;
    logic       fd_b, busy_b, err_b;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    always @(posedge clk) cyc <= cyc + 1;

    cam_capture_if #(.H_ACTIVE(4), .V_ACTIVE(2)) ia ();
    cam_capture_if #(.H_ACTIVE(4), .V_ACTIVE(4)) ib ();

    assign ia.pclk_i     = pclk;
    assign ia.href_i     = href;
    assign ia.vsync_i    = vsync;
    assign ia.cam_data_i = cdata;
    assign ib.pclk_i     = pclk;
    assign ib.href_i     = href;
    assign ib.vsync_i    = vsync;
    assign ib.cam_data_i = cdata;

    cam_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .DECIM(1), .SYNC_STAGES(2)) dut_a (
        .sys_clk_i(clk), .sys_rst_ni(rst_n), .cap_en_i(cap_en),
        .mode_i(mode), .err_clr_i(err_clr), .frame_done_o(fd_a),
        .busy_o(busy_a), .err_o(err_a), .bus(ia)
    );

    cam_capture #(.H_ACTIVE(4), .V_ACTIVE(4), .DECIM(2), .SYNC_STAGES(2)) dut_b (
        .sys_clk_i(clk), .sys_rst_ni(rst_n), .cap_en_i(cap_en),
        .mode_i(mode), .err_clr_i(err_clr), .frame_done_o(fd_b),
        .busy_o(busy_b), .err_o(err_b), .bus(ib)
    );

    typedef struct {
        int cyc;
        int r, g, b;
        int x, y;
        int sof, eol;
    } ev_t;

    ev_t a_log[$];
    ev_t b_log[$];
    int  fd_a_n = 0;
    int  fd_b_n = 0;
    int  fd_a_cyc = 0;
    int  b1q[$];
    int  vs_cyc = 0;

    always @(negedge clk) begin
        if (ia.pix_valid_o)
            a_log.push_back('{cyc, int'(ia.pix_r_o), int'(ia.pix_g_o),
                              int'(ia.pix_b_o), int'(ia.x_o), int'(ia.y_o),
                              int'(ia.pix_sof_o), int'(ia.pix_eol_o)});
        if (ib.pix_valid_o)
            b_log.push_back('{cyc, int'(ib.pix_r_o), int'(ib.pix_g_o),
                              int'(ib.pix_b_o), int'(ib.x_o), int'(ib.y_o),
                              int'(ib.pix_sof_o), int'(ib.pix_eol_o)});
        if (fd_a) begin
            fd_a_n   <= fd_a_n + 1;
            fd_a_cyc <= cyc;
        end
        if (fd_b) fd_b_n <= fd_b_n + 1;
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cam_byte(logic [7:0] b, output int rc);
        pclk  = 1'b0;
        cdata = b;
        wait_clk(4);
        pclk = 1'b1;
        rc   = cyc;
        wait_clk(4);
    endtask

    task automatic line(int np, logic [7:0] b0, logic [7:0] b1);
        int rc;
        href = 1'b1;
        wait_clk(4);
        for (int p = 0; p < np; p++) begin
            cam_byte(b0, rc);
            cam_byte(b1, rc);
            b1q.push_back(rc);
        end
        pclk = 1'b0;
        wait_clk(4);
        href = 1'b0;
        wait_clk(8);
    endtask

    task automatic frame(int nl, int np, int np0,
                         logic [7:0] b0, logic [7:0] b1, int drop_at);
        vsync = 1'b1;
        wait_clk(8);
        vsync = 1'b0;
        wait_clk(8);
        for (int l = 0; l < nl; l++) begin
            if (l == drop_at) cap_en = 1'b0;
            line((l == 0) ? np0 : np, b0, b1);
        end
        vsync  = 1'b1;
        vs_cyc = cyc;
        wait_clk(12);
    endtask

    initial begin
        int   s, f, rc;
        ev_t  e;
        rst_n = 1'b0; cap_en = 1'b0; err_clr = 1'b0; mode = 2'b00;
        pclk = 1'b0; href = 1'b0; vsync = 1'b1; cdata = 8'h00;
        wait_clk(3);
        chk("rst_valid", ia.pix_valid_o, 0);
        rst_n = 1'b1;
        wait_clk(3);
        chk("rst_busy", busy_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_fd", fd_a, 0);
        chk("rst_r", ia.pix_r_o, 0);
        chk("rst_x", ia.x_o, 0);

        // RGB565 solid red 4x2
        cap_en = 1'b1;
        wait_clk(2);
        chk("idle_to_wait", busy_a, 1);
        s = a_log.size(); f = fd_a_n; b1q.delete();
        frame(2, 4, 4, 8'hF8, 8'h00, -1);
        chk("565_cnt", a_log.size() - s, 8);
        for (int i = 0; i < 8; i++) begin
            if (s + i < a_log.size() && i < b1q.size()) begin
                e = a_log[s+i];
                chk("565_r", e.r, 'hFF);
                chk("565_g", e.g, 'h00);
                chk("565_b", e.b, 'h00);
                chk("565_x", e.x, i % 4);
                chk("565_y", e.y, i / 4);
                chk("565_sof", e.sof, (i == 0) ? 1 : 0);
                chk("565_eol", e.eol, ((i % 4) == 3) ? 1 : 0);
                chk("565_lat", e.cyc - b1q[i], 4);
            end
        end
        chk("565_fd", fd_a_n - f, 1);
        chk("fd_lat", fd_a_cyc - vs_cyc, 4);
        chk("565_err", err_a, 0);

        // RGB444
        mode = 2'b01;
        s = a_log.size();
        frame(2, 4, 4, 8'h0A, 8'h5C, -1);
        chk("444_cnt", a_log.size() - s, 8);
        if (a_log.size() > s) begin
            chk("444_r", a_log[s].r, 'hAA);
            chk("444_g", a_log[s].g, 'h55);
            chk("444_b", a_log[s].b, 'hCC);
        end

        // YUV luma
        mode = 2'b10;
        s = a_log.size();
        frame(2, 4, 4, 8'h80, 8'h37, -1);
        chk("yuv_cnt", a_log.size() - s, 8);
        if (a_log.size() > s) begin
            chk("yuv_r", a_log[s].r, 'h80);
            chk("yuv_g", a_log[s].g, 'h80);
            chk("yuv_b", a_log[s].b, 'h80);
        end

        // mode 11 falls back to RGB565
        mode = 2'b11;
        s = a_log.size();
        frame(2, 4, 4, 8'h0A, 8'h5C, -1);
        if (a_log.size() > s) begin
            chk("m3_r", a_log[s].r, 'h08);
            chk("m3_g", a_log[s].g, 'h49);
            chk("m3_b", a_log[s].b, 'hE7);
        end
        else chk("m3_cnt", a_log.size() - s, 8);

        // DECIM=2 on the 4x4 engine
        mode = 2'b00;
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        chk("clr_b", err_b, 0);
        s = b_log.size(); f = fd_b_n;
        frame(4, 4, 4, 8'hF8, 8'h00, -1);
        chk("dec_cnt", b_log.size() - s, 4);
        for (int j = 0; j < 4; j++) begin
            if (s + j < b_log.size()) begin
                e = b_log[s+j];
                chk("dec_x", e.x, (j % 2) * 2);
                chk("dec_y", e.y, (j / 2) * 2);
                chk("dec_sof", e.sof, (j == 0) ? 1 : 0);
                chk("dec_eol", e.eol, j % 2);
            end
        end
        chk("dec_fd", fd_b_n - f, 1);
        chk("dec_err", err_b, 0);

        // short line sets a sticky error
        frame(2, 4, 3, 8'hF8, 8'h00, -1);
        chk("short_err", err_a, 1);
        frame(2, 4, 4, 8'hF8, 8'h00, -1);
        chk("err_sticky", err_a, 1);
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        chk("err_clr", err_a, 0);

        // cap_en dropped in WAIT_VS, then mid-frame
        chk("wait_busy", busy_a, 1);
        cap_en = 1'b0;
        wait_clk(1);
        chk("wait_drop", busy_a, 0);
        cap_en = 1'b1;
        wait_clk(2);
        s = a_log.size(); f = fd_a_n;
        frame(2, 4, 4, 8'hF8, 8'h00, 1);
        chk("drop_cnt", a_log.size() - s, 8);
        chk("drop_fd", fd_a_n - f, 1);
        chk("drop_idle", busy_a, 0);
        s = a_log.size(); f = fd_a_n;
        frame(2, 4, 4, 8'hF8, 8'h00, -1);
        chk("off_cnt", a_log.size() - s, 0);
        chk("off_fd", fd_a_n - f, 0);

        // reset in the middle of a line
        cap_en = 1'b1;
        wait_clk(2);
        vsync = 1'b1;
        wait_clk(8);
        vsync = 1'b0;
        wait_clk(8);
        href = 1'b1;
        wait_clk(4);
        cam_byte(8'hF8, rc);
        cam_byte(8'h00, rc);
        cam_byte(8'hF8, rc);
        chk("pre_busy", busy_a, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_r", ia.pix_r_o, 0);
        chk("mid_valid", ia.pix_valid_o, 0);
        chk("mid_busy", busy_a, 0);
        chk("mid_x", ia.x_o, 0);
        pclk = 1'b0;
        wait_clk(4);
        href = 1'b0;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        s = a_log.size();
        line(4, 8'hF8, 8'h00);
        chk("partial", a_log.size() - s, 0);
        s = a_log.size(); f = fd_a_n;
        frame(2, 4, 4, 8'hF8, 8'h00, -1);
        chk("resume_cnt", a_log.size() - s, 8);
        if (a_log.size() > s) begin
            chk("resume_sof", a_log[s].sof, 1);
            chk("resume_x", a_log[s].x, 0);
            chk("resume_y", a_log[s].y, 0);
        end
        chk("resume_fd", fd_a_n - f, 1);
        chk("resume_err", err_a, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cam_capture.md
# cam_capture

Parametrised camera pixel-capture engine, successor to the fixed RGB capture path of the camera module. It oversamples the camera's pclk/href/vsync/data bus in the system clock domain and assembles byte pairs into pixels in one of three run-time formats: RGB565, RGB444 or YUV422 luma. It emits a one-cycle pixel strobe with frame/line markers, X/Y coordinates and optional 1:DECIM subsampling. It sits between the camera pins and the Sobel front end, beside the SCCB controller.

## Interface
- H_ACTIVE, 640: assembled pixels per line (href-high period).
- V_ACTIVE, 480: lines per frame.
- DECIM, 1: subsample factor in X and Y; legal values 1, 2, 4.
- SYNC_STAGES, 2: synchroniser depth for pclk/href/vsync/data; minimum 2.
- sys_clk_i  in  1  system clock; the only clock.
- sys_rst_ni  in  1  reset, asynchronous assert, active-low.
- cap_en_i  in  1  capture enable (level).
- mode_i  in  2  00 RGB565, 01 RGB444, 10 YUV422 luma, 11 treated as 00; sampled at frame start only.
- err_clr_i  in  1  clears err_o.
- vsync_i, href_i, pclk_i  in  1 each  camera timing (vsync high = blanking, href high = active line).
- cam_data_i  in  8  camera data bus.
- pix_r_o, pix_g_o, pix_b_o  out  8 each  expanded pixel.
- pix_valid_o  out  1  one-cycle pixel strobe.
- pix_sof_o, pix_eol_o  out  1 each  qualified by pix_valid_o: first emitted pixel of frame / last emitted pixel of line.
- x_o  out  clog2(H_ACTIVE)  column of the emitted pixel (pre-decimation).
- y_o  out  clog2(V_ACTIVE)  row of the emitted pixel (pre-decimation).
- frame_done_o  out  1  one-cycle pulse at frame end.
- busy_o  out  1  high in WAIT_VS or ACTIVE.
- err_o  out  1  sticky geometry error.

## Operation
- Front end: all camera inputs pass through SYNC_STAGES flops. A pclk rising edge ("tick") is detected from the last two stages. Data and href are taken from the same stage as pclk, so they stay aligned.
- FSM states:
  - IDLE → WAIT_VS when cap_en_i = 1.
  - WAIT_VS → ACTIVE on a synchronised vsync falling edge; latch mode_i and clear x, y and the byte phase.
  - ACTIVE → DONE on a vsync rising edge.
  - DONE lasts 1 cycle and pulses frame_done_o, then goes to WAIT_VS if cap_en_i = 1, else IDLE.
  - Deasserting cap_en_i during ACTIVE does not abort: the frame completes first.
  - Deasserting cap_en_i in WAIT_VS returns to IDLE immediately.
- Byte pairing, on each tick with href = 1 in ACTIVE:
  - Phase 0: store the byte.
  - Phase 1: assemble the pixel and increment x. Pixels past H_ACTIVE-1 are dropped, and x saturates.
  - Phase resets to 0 on each href rising edge.
- Format expansion (first byte = B0, second = B1):
  - RGB565: r5 = B0[7:3]; g6 = {B0[2:0], B1[7:5]}; b5 = B1[4:0]. Expand as r = {r5, r5[4:2]}, g = {g6, g6[5:4]}, b = {b5, b5[4:2]}.
  - RGB444: r4 = B0[3:0], g4 = B1[7:4], b4 = B1[3:0]. Each channel is {c4, c4}.
  - YUV422 luma: Y = B0; r = g = b = Y; B1 is discarded.
- Emission: pix_valid_o is asserted only when x % DECIM == 0 and y % DECIM == 0.
  - pix_sof_o: first emitted pixel since ACTIVE entry.
  - pix_eol_o: x == H_ACTIVE - DECIM.
- Line end (href falling edge): if x != H_ACTIVE or phase != 0, set err_o. Then increment y (saturating at V_ACTIVE) and clear x.
- Frame end (vsync rising edge in ACTIVE): if y != V_ACTIVE, set err_o. An href still high at that point is treated as a line end first.
- err_o: set events have priority over err_clr_i in the same cycle.

## Timing
- Reset values: every output is 0, FSM is IDLE, all counters are 0, synchronisers are 0.
- Latency: pix_valid_o rises exactly SYNC_STAGES+2 sys_clk cycles after the pclk rising edge carrying B1 (sync stages + edge detect + output register).
- pix_* data, x_o, y_o and markers are registered and valid only while pix_valid_o = 1; they hold their last value otherwise.
- frame_done_o is asserted SYNC_STAGES+2 cycles after the vsync rising edge.
- Input constraint: pclk high and low phases are each ≥ 2 sys_clk periods (sys_clk ≥ 4× pclk). Violations are undefined and are not detected.
- Reset mid-frame: all outputs return to reset values asynchronously. After release, the next vsync falling edge is awaited; a partial frame is never emitted.

## Test plan
- RGB565, 4×2 frame (H_ACTIVE=4, V_ACTIVE=2), bytes F8,00 per pixel → 8 strobes with r=FF, g=00, b=00; sof on (0,0); eol on x=3; one frame_done_o; err_o=0.
- RGB444 byte pair 0A,5C → r=AA, g=55, b=CC. YUV luma byte pair 80,xx → r=g=b=80.
- DECIM=2 on a 4×4 frame → exactly 4 strobes at (0,0),(2,0),(0,2),(2,2); eol on x=2.
- Short line (3 pixels with H_ACTIVE=4) → err_o=1 persists through the next frame; err_clr_i pulse → 0.
- cap_en_i dropped mid-frame → frame completes, frame_done_o pulses, FSM returns to IDLE, and the following frame produces no strobes.
- Reset asserted mid-line → all outputs 0 immediately; after release, capture resumes at the next vsync falling edge with sof at (0,0).
